diceroll_button_cond: RTL and testbench

//  Upstream input stage for the dice roller: conditions the raw ROLL push-button.

---
 rtl/diceroll_button_cond_pkg.sv | 16 +
 rtl/diceroll_sync2.sv | 21 ++
 rtl/diceroll_button_cond.sv | 117 +++++++++++
 tb/tb_diceroll_button_cond.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diceroll_button_cond_pkg.sv
// Shared definitions for the dice roller front end: FSM state encodings and
// default timing/width values reused by the button conditioner and dice stage.
package diceroll_button_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LONG_CYCLES     = 16;
  localparam int DEF_SEED_W          = 8;

endpackage

// File: rtl/diceroll_sync2.sv
// Two-flop synchroniser for the asynchronous button level; clears to 0 on reset.
module diceroll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/diceroll_button_cond.sv
// ROLL button conditioner: synchronise, debounce and edge-detect the raw button,
// measure hold duration as a dice seed and flag long presses.
module diceroll_button_cond
  import diceroll_button_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int SEED_W          = DEF_SEED_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              roll_raw,
  output logic              roll_level,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              long_press,
  output logic [SEED_W-1:0] seed,
  output logic              seed_valid
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic              s;
  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SEED_W-1:0] hold_cnt;
  logic [LONG_W-1:0] long_cnt, long_nxt;
  logic              press_acc, release_acc, level_nxt, in_hold;

  diceroll_sync2 u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (roll_raw),
    .q     (s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    press_acc   = 1'b0;
    release_acc = 1'b0;
    case (state)
      IDLE: begin
        if (s) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          press_acc = 1'b1;
        end
      end
      HELD: begin
        if (!s) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          release_acc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Debounced level is high from HELD entry until the release is accepted.
  always_comb begin
    level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
    in_hold   = (state == HELD) || (state == RELEASE_WAIT);
  end

  always_comb begin
    long_nxt = long_cnt;
    if (press_acc) long_nxt = '0;
    else if (in_hold && (long_cnt != LONG_MAX)) long_nxt = long_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt           <= '0;
      hold_cnt      <= '0;
      long_cnt      <= '0;
      roll_level    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      seed          <= '0;
      seed_valid    <= 1'b0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else if ((state == PRESS_WAIT) || (state == RELEASE_WAIT)) cnt <= cnt + 1'b1;

      // Bounce returns to HELD keep counting, so the seed includes them.
      if (press_acc) hold_cnt <= '0;
      else if (in_hold) hold_cnt <= hold_cnt + 1'b1;

      long_cnt      <= long_nxt;
      long_press    <= level_nxt && (long_nxt == LONG_MAX);
      roll_level    <= level_nxt;
      press_pulse   <= press_acc;
      release_pulse <= release_acc;
      seed_valid    <= release_acc;
      if (release_acc) seed <= hold_cnt;
    end
  end

endmodule

// File: tb/tb_diceroll_button_cond.sv
// Self-checking bench for diceroll_button_cond: directed scenarios plus random
// button activity against a run-length model of the debounced button.
module tb_diceroll_button_cond;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int SW   = 8;

  logic          CLK;
  logic          RST;
  logic          roll_raw;
  logic          roll_level, press_pulse, release_pulse, long_press, seed_valid;
  logic [SW-1:0] seed;
  logic [12:0]   dut_vec;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: synchroniser pipe, accepted level, run length of
  // disagreeing samples, and edges elapsed since the press was accepted.
  bit          m_sy1, m_sy2, m_level, m_pp, m_rp, m_lp;
  int          m_run, m_since;
  logic [SW-1:0] m_seed;

  diceroll_button_cond #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG),
    .SEED_W          (SW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .roll_raw      (roll_raw),
    .roll_level    (roll_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .seed          (seed),
    .seed_valid    (seed_valid)
  );

  assign dut_vec = {roll_level, press_pulse, release_pulse, long_press, seed_valid, seed};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d expired without reaching the summary", cyc);
    $fatal(1, "watchdog");
  end

  task automatic model_reset;
    m_sy1 = 0; m_sy2 = 0; m_level = 0; m_pp = 0; m_rp = 0; m_lp = 0;
    m_run = 0; m_since = 0; m_seed = '0;
  endtask

  task automatic model_edge(input bit raw_v);
    bit s_v;
    s_v   = m_sy2;
    m_sy2 = m_sy1;
    m_sy1 = raw_v;
    m_pp  = 0;
    m_rp  = 0;
    if (m_level) m_since++;
    if (s_v != m_level) m_run++;
    else m_run = 0;
    if (m_run == DEB + 1) begin
      m_run = 0;
      if (!m_level) begin
        m_level = 1; m_pp = 1; m_since = 0;
      end else begin
        m_level = 0; m_rp = 1; m_seed = SW'(m_since - 1);
      end
    end
    m_lp = m_level && (m_since >= LONG);
  endtask

  function automatic logic [12:0] model_vec();
    return {m_level, m_pp, m_rp, m_lp, m_rp, m_seed};
  endfunction

  task automatic tick;
    @(posedge CLK);
    if (!RST) model_reset();
    else model_edge(roll_raw);
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    roll_raw = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      roll_raw = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (dut_vec !== 13'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc, dut_vec);
      end
    end
    roll_raw = 1'b0;
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec !== 13'd0 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=0", cyc, dut_vec);
      end
    end
  endtask

  task automatic test_bounce;
    roll_raw = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 14; i++) begin
      roll_raw = (i < 2);
      tick();
      checks++;
      if (press_pulse !== 1'b0 || roll_level !== 1'b0 || dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_long_press;
    int n, p, lr, r;
    roll_raw = 1'b0;
    repeat (6) tick();
    roll_raw = 1'b1;
    n = cyc + 1;
    p = -1;
    for (int i = 0; i < 20 && p < 0; i++) begin
      tick();
      if (press_pulse === 1'b1) p = cyc;
    end
    checks++;
    if (p != n + 6) begin
      errors++;
      $display("FAIL press_latency got=%0d exp=%0d", p - n, 6);
    end
    if (p < 0) p = cyc;
    lr = -1;
    while (cyc < p + 19) begin
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL long_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
      if (long_press === 1'b1 && lr < 0) lr = cyc;
    end
    roll_raw = 1'b0;
    r = -1;
    for (int i = 0; i < 20 && r < 0; i++) begin
      tick();
      if (release_pulse === 1'b1) begin
        r = cyc;
        checks++;
        if (seed !== 8'd25 || seed_valid !== 1'b1 || long_press !== 1'b0 || roll_level !== 1'b0) begin
          errors++;
          $display("FAIL long_release_outputs seed=%0d sv=%b lp=%b lvl=%b exp seed=25 sv=1 lp=0 lvl=0",
                   seed, seed_valid, long_press, roll_level);
        end
      end
    end
    checks++;
    if (lr != p + 16) begin
      errors++;
      $display("FAIL long_rise got=%0d exp=%0d", lr - p, 16);
    end
    checks++;
    if (r != p + 26) begin
      errors++;
      $display("FAIL release_latency got=%0d exp=%0d", r - p, 26);
    end
    tick();
    checks++;
    if (seed !== 8'd25 || seed_valid !== 1'b0 || release_pulse !== 1'b0) begin
      errors++;
      $display("FAIL seed_hold seed=%0d sv=%b rp=%b exp seed=25 sv=0 rp=0", seed, seed_valid, release_pulse);
    end
  endtask

  task automatic test_release_bounce;
    int p, x, r, nrel;
    roll_raw = 1'b0;
    repeat (6) tick();
    roll_raw = 1'b1;
    p = -1;
    for (int i = 0; i < 20 && p < 0; i++) begin
      tick();
      if (press_pulse === 1'b1) p = cyc;
    end
    if (p < 0) p = cyc;
    while (cyc < p + 9) tick();
    nrel = 0;
    for (int i = 0; i < 12; i++) begin
      roll_raw = !(i < 2);
      tick();
      if (release_pulse === 1'b1) nrel++;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++;
        $display("FAIL rel_bounce_model cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
      end
    end
    checks++;
    if (nrel != 0 || roll_level !== 1'b1) begin
      errors++;
      $display("FAIL rel_bounce_strobe got releases=%0d lvl=%b exp releases=0 lvl=1", nrel, roll_level);
    end
    roll_raw = 1'b0;
    x = cyc + 1;
    r = -1;
    for (int i = 0; i < 20 && r < 0; i++) begin
      tick();
      if (release_pulse === 1'b1) r = cyc;
    end
    checks++;
    if (r != x + 6 || seed !== SW'(x + 6 - p - 1)) begin
      errors++;
      $display("FAIL rel_bounce_seed got rel=%0d seed=%0d exp rel=%0d seed=%0d",
               r - x, seed, 6, SW'(x + 6 - p - 1));
    end
  endtask

  task automatic test_reset_mid_held;
    int p, n, p2, nrel;
    roll_raw = 1'b0;
    repeat (6) tick();
    roll_raw = 1'b1;
    p = -1;
    for (int i = 0; i < 20 && p < 0; i++) begin
      tick();
      if (press_pulse === 1'b1) p = cyc;
    end
    repeat (5) tick();
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 13'd0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", dut_vec);
    end
    nrel = 0;
    repeat (3) begin
      tick();
      checks++;
      if (dut_vec !== 13'd0) begin
        errors++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h exp=0", cyc, dut_vec);
      end
    end
    RST = 1'b1;
    n = cyc + 1;
    p2 = -1;
    for (int i = 0; i < 20 && p2 < 0; i++) begin
      tick();
      if (release_pulse === 1'b1 || seed_valid === 1'b1) nrel++;
      if (press_pulse === 1'b1) p2 = cyc;
    end
    checks++;
    if (p2 != n + 6 || nrel != 0 || seed !== '0) begin
      errors++;
      $display("FAIL reset_repress got lat=%0d rel=%0d seed=%0d exp lat=6 rel=0 seed=0", p2 - n, nrel, seed);
    end
  endtask

  task automatic test_random;
    int seg;
    bit lvl;
    lvl = 0;
    for (int k = 0; k < 300; k++) begin
      lvl = !lvl;
      seg = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 9);
      roll_raw = lvl;
      for (int i = 0; i < seg; i++) begin
        if ($urandom_range(0, 199) == 0) begin
          #2;
          RST = 1'b0;
          #1;
          model_reset();
          checks++;
          if (dut_vec !== 13'd0) begin
            errors++;
            $display("FAIL random_reset cyc=%0d got=%h exp=0", cyc, dut_vec);
          end
          tick();
          RST = 1'b1;
        end
        tick();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++;
          $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, model_vec());
        end
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    roll_raw = 1'b0;
    model_reset();
    test_reset();
    test_bounce();
    test_long_press();
    test_release_bounce();
    test_reset_mid_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
